// File: rtl/inst_encoder.sv
// inst_encoder
// Packs MIPS instruction fields into 32-bit words and queues each word with
// its target byte address. A bundle is consumed when in_valid && in_ready.
// Legal bundles are encoded and pushed into a small FIFO, and the PC then
// advances by 4. Illegal bundles are dropped and counted.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   flush                 synchronous clear of the FIFO and PC; err_count is kept
//   in_valid/in_ready     input handshake for one field bundle
//   in_fmt                0=R, 1=I, 2=J, 3=illegal
//   in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_addr
//                         instruction fields; fields the format does not use are ignored
//   out_valid/out_ready   output handshake at the FIFO head
//   out_instruction       encoded word at the head
//   out_pc                byte address paired with the head word
//   err_pulse             high for one cycle after a rejected bundle
//   err_count             rejected-bundle count, saturates at 255
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  mem_word_reg [DEPTH];
  logic [31:0]  mem_pc_reg   [DEPTH];
  logic         err_pulse_reg;
  logic [7:0]   err_count_reg;

  logic         full;
  logic         empty;
  logic         legal;
  logic [31:0]  enc_word;
  logic         accept;
  logic         push;
  logic         pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A pop does not open a slot for a push in the same cycle. in_ready only
  // rises on the cycle after the pop.
  assign in_ready  = !rst && !flush && !full;
  assign out_valid = !empty;

  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  // A flush overrides any same-cycle pop.
  assign pop    = out_valid && out_ready && !flush;

  // Check that the format and opcode agree, then encode the word.
  always_comb begin
    legal    = 1'b0;
    enc_word = 32'h0;
    case (in_fmt)
      2'd0: begin
        legal    = (in_opcode == 6'h00);
        enc_word = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
      end
      2'd1: begin
        legal    = (in_opcode != 6'h00) && (in_opcode != 6'h02) && (in_opcode != 6'h03);
        enc_word = {in_opcode, in_rs, in_rt, in_imm};
      end
      2'd2: begin
        legal    = (in_opcode == 6'h02) || (in_opcode == 6'h03);
        enc_word = {in_opcode, in_addr};
      end
      default: begin
        legal    = 1'b0;
        enc_word = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // The PC wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= BASE_ADDR;
    end else if (flush) begin
      pc_reg <= BASE_ADDR;
    end else if (push) begin
      pc_reg <= pc_reg + 32'd4;
    end
  end

  // The storage is reset so that the head reads 0 / BASE_ADDR after reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_word_reg[gi] <= 32'h0;
          mem_pc_reg[gi]   <= BASE_ADDR;
        end else if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          mem_word_reg[gi] <= enc_word;
          mem_pc_reg[gi]   <= pc_reg;
        end
      end
    end
  endgenerate

  assign out_instruction = mem_word_reg[rd_ptr_reg[AW-1:0]];
  assign out_pc          = mem_pc_reg[rd_ptr_reg[AW-1:0]];

  // flush forces in_ready low, so no bundle can be rejected during a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse_reg <= 1'b0;
      err_count_reg <= 8'd0;
    end else begin
      err_pulse_reg <= accept && !legal;
      if (accept && !legal && (err_count_reg != 8'hFF))
        err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;

  // dut0: default BASE_ADDR
  logic        flush, in_valid, in_ready, out_valid, out_ready, err_pulse;
  logic [1:0]  in_fmt;
  logic [5:0]  in_opcode, in_funct;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_addr;
  logic [31:0] out_instruction, out_pc;
  logic [7:0]  err_count;

  // dut1: BASE_ADDR near the top of the address space
  logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1, err_pulse1;
  logic [1:0]  in_fmt1;
  logic [5:0]  in_opcode1;
  logic [15:0] in_imm1;
  logic [31:0] out_instruction1, out_pc1;
  logic [7:0]  err_count1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  inst_encoder #(.BASE_ADDR(32'hFFFF_FFF8), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_fmt(in_fmt1),
    .in_opcode(in_opcode1), .in_rs(5'd0), .in_rt(5'd1), .in_rd(5'd0),
    .in_shamt(5'd0), .in_funct(6'd0), .in_imm(in_imm1), .in_addr(26'd0),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_instruction(out_instruction1), .out_pc(out_pc1),
    .err_pulse(err_pulse1), .err_count(err_count1)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [1:0] f, input logic [5:0] op,
                            input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh,
                            input logic [5:0] fn, input logic [15:0] imm,
                            input logic [25:0] ad);
    in_fmt = f; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_addr = ad;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_instruction !== 32'h0) begin errors++; $display("FAIL reset_out_instruction got=%h exp=0", out_instruction); end
    checks++;
    if (out_pc !== 32'h0 || out_pc1 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_out_pc got=%h/%h exp=0/fffffff8", out_pc, out_pc1); end
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL reset_err got=%b/%0d exp=0/0", err_pulse, err_count); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    $display("reset: checked reset values");
  endtask

  task automatic test_r_type();
    set_bundle(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_instruction !== 32'h0022_1820 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL r_type got v=%b w=%h pc=%h exp v=1 w=00221820 pc=0", out_valid, out_instruction, out_pc);
    end
    $display("r_type: add word=%h pc=%h", out_instruction, out_pc);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL r_type_pop got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h2008_0005; exp_w[1] = 32'h8FA9_0004; exp_w[2] = 32'h0810_0000;
    do_flush();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_bundle(2'd1, 6'h08, 5'd0,  5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'h0);
        1: set_bundle(2'd1, 6'h23, 5'd29, 5'd9, 5'd0, 5'd0, 6'd0, 16'd4, 26'h0);
        default: set_bundle(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000);
      endcase
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_instruction !== exp_w[i] || out_pc !== 32'(4 * i)) begin
        errors++;
        $display("FAIL back_to_back_%0d got v=%b w=%h pc=%h exp v=1 w=%h pc=%h",
                 i, out_valid, out_instruction, out_pc, exp_w[i], 32'(4 * i));
      end
      $display("back_to_back: word=%h pc=%h", out_instruction, out_pc);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL back_to_back_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_errors();
    do_flush();
    in_valid = 1'b1;
    set_bundle(2'd0, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    tick();
    checks++;
    if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL err_first got pulse=%b v=%b exp pulse=1 v=0", err_pulse, out_valid);
    end
    set_bundle(2'd3, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd2 || out_valid !== 1'b0) begin
      errors++; $display("FAIL err_second got pulse=%b cnt=%0d v=%b exp 1/2/0", err_pulse, err_count, out_valid);
    end
    tick();
    checks++;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL err_pulse_end got=%b exp=0", err_pulse); end
    // jal: the PC must still be 0 after the rejects.
    set_bundle(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FF_FFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_instruction !== 32'h0FFF_FFFF || out_pc !== 32'h0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL err_then_legal got w=%h pc=%h pulse=%b exp 0fffffff/0/0", out_instruction, out_pc, err_pulse);
    end
    $display("errors: err_count=%0d next word=%h pc=%h", err_count, out_instruction, out_pc);
  endtask

  task automatic test_full();
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_bundle(2'd1, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'(i), 26'h0);
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== (i < 4)) begin errors++; $display("FAIL full_in_ready_%0d got=%b exp=%b", i, in_ready, (i < 4)); end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_instruction !== 32'h2000_0000 || out_pc !== 32'h0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_hold got w=%h pc=%h v=%b exp 20000000/0/1", out_instruction, out_pc, out_valid);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_instruction !== (32'h2000_0000 | 32'(k)) || out_pc !== 32'(4 * k)) begin
        errors++; $display("FAIL full_drain_%0d got v=%b w=%h pc=%h exp v=1 w=%h pc=%h",
                           k, out_valid, out_instruction, out_pc, 32'h2000_0000 | 32'(k), 32'(4 * k));
      end
      $display("full: drained word=%h pc=%h", out_instruction, out_pc);
      tick();
      if (k == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got=%b exp=1", in_ready); end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    // PC is 0x10 here; queue 3 entries, then flush with a push and a pop.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_bundle(2'd1, 6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'(i + 7), 26'h0);
      tick();
    end
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd2) begin
      errors++; $display("FAIL flush_state got v=%b cnt=%0d exp 0/2", out_valid, err_count);
    end
    set_bundle(2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_pc !== 32'h0 || out_instruction !== 32'h0085_3080) begin
      errors++; $display("FAIL flush_pc got w=%h pc=%h exp 00853080/0", out_instruction, out_pc);
    end
    $display("flush: post-flush word=%h pc=%h", out_instruction, out_pc);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    in_fmt1 = 2'd1; in_opcode1 = 6'h08; in_valid1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_imm1 = 16'(i);
      tick();
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid1 !== 1'b1 || out_pc1 !== exp_pc[i] || out_instruction1 !== (32'h2001_0000 | 32'(i))) begin
        errors++; $display("FAIL wrap_%0d got v=%b w=%h pc=%h exp v=1 w=%h pc=%h",
                           i, out_valid1, out_instruction1, out_pc1, 32'h2001_0000 | 32'(i), exp_pc[i]);
      end
      $display("wrap: word=%h pc=%h", out_instruction1, out_pc1);
      tick();
    end
    out_ready1 = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    set_bundle(2'd1, 6'h08, 5'd0, 5'd3, 5'd0, 5'd0, 6'h0, 16'h55, 26'h0);
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_instruction !== 32'h0 ||
        out_pc !== 32'h0 || err_count !== 8'd0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL async_reset got v=%b r=%b w=%h pc=%h cnt=%0d p=%b exp all reset",
                         out_valid, in_ready, out_instruction, out_pc, err_count, err_pulse);
    end
    $display("async_reset: outputs after mid-cycle reset v=%b w=%h", out_valid, out_instruction);
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_bundle(2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    in_fmt1 = 2'd0; in_opcode1 = 6'h0; in_imm1 = 16'h0;
    test_reset();
    test_r_type();
    test_back_to_back();
    test_errors();
    test_full();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
